// File: rtl/mem_sp_param.sv
// Single-port byte-writable RAM that zero-fills itself after reset, with optional per-byte
// even parity enabled by defining MEM_PARITY_EN; RD_LAT selects async (0) or registered (1) read.
module mem_sp_param #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4,
  parameter int RD_LAT = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  wr_enb,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic [DATA_W/8-1:0]   wr_be,
  input  logic                  par_inj,
  output logic [DATA_W-1:0]     rd_data,
  output logic                  rd_valid,
  output logic                  ready,
  output logic                  par_err
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int NB    = DATA_W / 8;
`ifdef MEM_PARITY_EN
  localparam int LW = 9;
`else
  localparam int LW = 8;
`endif

  generate
    if (RD_LAT != 0 && RD_LAT != 1) begin : g_bad_lat
      $error("mem_sp_param: RD_LAT must be 0 or 1");
    end
    if (DATA_W % 8 != 0 || DATA_W < 8) begin : g_bad_width
      $error("mem_sp_param: DATA_W must be a non-zero multiple of 8");
    end
  endgenerate

  typedef enum logic {INIT, RUN} state_t;

  state_t              state_reg, state_next;
  logic [ADDR_W-1:0]   cnt_reg, cnt_next;
  logic                init_we;
  logic                wr_go;
  logic                rd_go;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   rd_word;
  logic [NB-1:0]       lane_err;
  logic                any_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= INIT;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // The clear counter walks every word once; leaving INIT follows the last word's clear.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      INIT: begin
        cnt_next = cnt_reg + 1'b1;
        if (cnt_reg == '1) state_next = RUN;
      end
      RUN:     state_next = RUN;
      default: state_next = INIT;
    endcase
  end

  always_comb begin
    ready   = 1'b0;
    init_we = 1'b0;
    case (state_reg)
      INIT:    init_we = 1'b1;
      RUN:     ready   = 1'b1;
      default: init_we = 1'b1;
    endcase
  end

  assign wr_go    = ready & en & wr_enb;
  assign rd_go    = ready & en & ~wr_enb;
  assign mem_addr = init_we ? cnt_reg : addr;

  genvar gi;
  generate
    for (gi = 0; gi < NB; gi++) begin : g_lane
      logic [LW-1:0] ram [DEPTH];
      logic [LW-1:0] wr_lane;
      logic [LW-1:0] rd_lane;
      logic          we;

      assign we = init_we | (wr_go & wr_be[gi]);
`ifdef MEM_PARITY_EN
      // Stored bit makes the 9-bit lane even; par_inj flips it to plant an error.
      assign wr_lane = init_we ? '0 : {(^wr_data[8*gi +: 8]) ^ par_inj, wr_data[8*gi +: 8]};
      assign lane_err[gi] = rd_lane[8] ^ (^rd_lane[7:0]);
`else
      assign wr_lane = init_we ? '0 : wr_data[8*gi +: 8];
      assign lane_err[gi] = 1'b0;
`endif

      always_ff @(posedge clk) begin
        if (we) ram[mem_addr] <= wr_lane;
      end

      assign rd_lane              = ram[addr];
      assign rd_word[8*gi +: 8]   = rd_lane[7:0];
    end
  endgenerate

`ifdef MEM_PARITY_EN
  assign any_err = |lane_err;
`else
  logic unused_par;
  assign unused_par = par_inj ^ (|lane_err);
  assign any_err    = 1'b0;
`endif

  generate
    if (RD_LAT == 1) begin : g_rd_reg
      logic [DATA_W-1:0] rd_data_reg;
      logic              rd_valid_reg;
      logic              par_err_reg;

      // Output register keeps the last read word between reads.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rd_data_reg  <= '0;
          rd_valid_reg <= 1'b0;
          par_err_reg  <= 1'b0;
        end else begin
          rd_valid_reg <= rd_go;
          par_err_reg  <= rd_go & any_err;
          if (rd_go) rd_data_reg <= rd_word;
        end
      end

      assign rd_data  = rd_data_reg;
      assign rd_valid = rd_valid_reg;
      assign par_err  = par_err_reg;
    end else begin : g_rd_comb
      assign rd_data  = rd_word;
      assign rd_valid = rd_go;
      assign par_err  = rd_go & any_err;
    end
  endgenerate

endmodule

// File: doc/mem_sp_param.md
MEM_SP_PARAM -- requirements
Module: mem_sp_param

Interface
REQ-001 Parameter DATA_W, default 32, word width in bits; SHALL be a multiple of 8.
REQ-002 Parameter ADDR_W, default 4, address width; depth DEPTH = 2**ADDR_W words.
REQ-003 Parameter RD_LAT, default 0, read latency: 0 = asynchronous read, 1 = registered read; other values SHALL be rejected at elaboration.
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 en  input  1  request valid; accepted only when ready=1.
REQ-007 wr_enb  input  1  1 = write, 0 = read, qualified by en.
REQ-008 addr  input  ADDR_W  word address.
REQ-009 wr_data  input  DATA_W  write data.
REQ-010 wr_be  input  DATA_W/8  byte enables; bit i covers wr_data[8i+7:8i].
REQ-011 par_inj  input  1  parity error injection (see Configuration).
REQ-012 rd_data  output  DATA_W  read data.
REQ-013 rd_valid  output  1  rd_data valid for an accepted read.
REQ-014 ready  output  1  block accepts requests.
REQ-015 par_err  output  1  parity mismatch on the current read.

Function
REQ-016 FSM states INIT and RUN; reset enters INIT.
REQ-017 INIT: an ADDR_W-bit counter clears word 0..DEPTH-1 to zero, one word per cycle; ready=0; en is ignored.
REQ-018 INIT -> RUN on the cycle after word DEPTH-1 is cleared, i.e. exactly DEPTH cycles after rst_n rises; ready=1 in RUN; RUN has no exit except reset.
REQ-019 Write (RUN, en=1, wr_enb=1): each byte with wr_be[i]=1 updates at the clock edge; bytes with wr_be[i]=0 are unchanged; wr_be=0 is a legal no-op.
REQ-020 Read (RUN, en=1, wr_enb=0), RD_LAT=0: rd_data = mem[addr] combinationally, rd_valid = en & ~wr_enb & ready combinationally.
REQ-021 Read, RD_LAT=1: rd_data registered at the edge, rd_valid pulses one cycle after acceptance; rd_data holds the last read value otherwise.
REQ-022 Single port: one operation per cycle; write followed by read of the same address in the next cycle returns the new data in both modes.
REQ-023 RD_LAT=0 during a write cycle: rd_data shows the pre-write contents until the edge; rd_valid=0.
REQ-024 Address space is exactly DEPTH words; no wrap or alias; addr 0 and DEPTH-1 are independent.

Reset
REQ-025 rst_n=0 at any time, including mid-INIT or mid-read: FSM -> INIT, counter=0, ready=0, rd_valid=0, par_err=0, registered rd_data=0.
REQ-026 Array contents are not reset asynchronously; the re-run INIT sequence zeroes them.

Configuration
REQ-027 Macro MEM_PARITY_EN defined: one even-parity bit is stored per byte and written with the byte; par_inj=1 on a write stores inverted parity for the enabled bytes; INIT writes correct parity.
REQ-028 With MEM_PARITY_EN, par_err asserts for any byte-parity mismatch on a read, aligned with rd_valid (same timing, combinational or registered per RD_LAT).
REQ-029 Without MEM_PARITY_EN: no parity storage; par_inj is ignored; par_err is tied 0; port list is unchanged.

Verification
REQ-030 Release rst_n -> ready=0 for exactly 16 cycles, then 1; read addr 5 -> rd_data=0x00000000.
REQ-031 Write 0xDEADBEEF, wr_be=4'hF, addr 3; read addr 3 -> 0xDEADBEEF; rd_valid same cycle (RD_LAT=0) or next cycle (RD_LAT=1).
REQ-032 After INIT, write 0x11223344, wr_be=4'b0101, addr 7; read addr 7 -> 0x00220044.
REQ-033 Write 0xAAAAAAAA to addr 0 and 0x55555555 to addr 15, back-to-back; read 15 then 0 -> 0x55555555, 0xAAAAAAAA.
REQ-034 Write addr 2, pulse rst_n low mid-read -> rd_valid=0 immediately, ready=0 for 16 cycles; read addr 2 -> 0x00000000.
REQ-035 MEM_PARITY_EN: write addr 9 with par_inj=1; read addr 9 -> par_err=1 with rd_valid; rewrite with par_inj=0 -> par_err=0; without macro -> par_err=0 throughout.
